// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - in-order instruction prefetch queue with redirect, drain and halt.
// Optional same-cycle response bypass to IF when PFQ_BYPASS_EN is defined.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    output logic                     imem_req_valid,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     halt,
    output logic                     if_valid,
    output logic [31:0]              if_ir,
    output logic [31:0]              if_npc,
    input  logic                     if_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     pc;
    logic [31:0]     rsp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   infl_next;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [31:0]     ir_mem  [DEPTH];
    logic [31:0]     npc_mem [DEPTH];

    logic [CW:0]     credit_sum;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            head_valid;
    logic            bypass_valid;
    logic            bypass_take;
    logic            push;
    logic            pop;

    // Credit uses only registered counts, so if_ready never reaches imem_req_valid.
    assign credit_sum     = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = rst_n & (state == RUN) & ~halt & (credit_sum < DEPTH_W);
    assign imem_req_addr  = pc[ADDR_W-1:0];
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_drop   = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_keep   = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
    assign head_valid = (count != '0);

`ifdef PFQ_BYPASS_EN
    assign bypass_valid = rst_n & rsp_keep & ~head_valid;
`else
    assign bypass_valid = 1'b0;
`endif

    assign bypass_take = bypass_valid & if_ready;
    assign push        = rsp_keep & ~bypass_take;
    assign pop         = head_valid & if_ready & ~redirect_valid;
    assign if_valid    = rst_n & (head_valid | bypass_valid);
    assign occupancy   = count;

    // Every outstanding request, stale or not, is counted until its response returns.
    assign infl_next = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

    always_comb begin
        if_ir  = '0;
        if_npc = '0;
        if (head_valid) begin
            if_ir  = ir_mem[rd_ptr];
            if_npc = npc_mem[rd_ptr];
        end else if (bypass_valid) begin
            if_ir  = imem_rsp_data;
            if_npc = rsp_pc + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = (infl_next != '0) ? DRAIN : RUN;
        end else begin
            case (state)
                RUN:     if (halt) state_next = HALTED;
                DRAIN:   if (drop_cnt == '0) state_next = RUN;
                HALTED:  if (!halt) state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            inflight <= infl_next;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop_cnt <= infl_next;
            end else begin
                if (req_fire) pc <= pc + 32'd1;
                if (rsp_keep) rsp_pc <= rsp_pc + 32'd1;
                if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Payload storage needs no reset; outputs are masked by head_valid.
    always_ff @(posedge clk1) begin
        if (push) begin
            ir_mem[wr_ptr]  <= imem_rsp_data;
            npc_mem[wr_ptr] <= rsp_pc + 32'd1;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - directed self-checking bench for inst_prefetch_queue.
// Expected latency depends on PFQ_BYPASS_EN.
module tb_inst_prefetch_queue;

`ifdef PFQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [9:0]  imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_npc;
    logic        if_ready = 1'b0;
    logic [2:0]  occupancy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;

    logic [9:0]  pend_addr[$];
    int          pend_due[$];
    int          req_log[$];
    int          req_cyc[$];
    logic [31:0] got_ir[$];
    logic [31:0] got_npc[$];
    logic        arm_lat = 1'b0;
    int          first_valid_cyc = -1;

    inst_prefetch_queue #(.DEPTH(4), .ADDR_W(10), .RESET_PC(32'd0)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt),
        .if_valid(if_valid), .if_ir(if_ir), .if_npc(if_npc), .if_ready(if_ready),
        .occupancy(occupancy)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {22'd0, a[9:0]};
    endfunction

    // Memory: responses at +1, request handshake sampled at +4; tasks drive at +2.
    always @(posedge clk1) begin
        #1;
        if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rsp_valid = 1'b0;
        end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word({22'd0, pend_addr.pop_front()});
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #3;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            req_log.push_back(int'(imem_req_addr));
            req_cyc.push_back(cyc);
        end
    end

    always @(negedge clk1) begin
        if (rst_n && if_valid && if_ready && !redirect_valid) begin
            got_ir.push_back(if_ir);
            got_npc.push_back(if_npc);
        end
        if (arm_lat && rst_n && if_valid) begin
            first_valid_cyc = cyc;
            arm_lat = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk1);
        #2;
    endtask

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        got_ir.delete();
        got_npc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        halt = 1'b0;
        step();
        step();
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk1);
        n_tests++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %0b expected 0", imem_req_valid); end
        n_tests++;
        if (imem_req_addr !== 10'd0) begin n_fail++; $display("FAIL reset_req_addr: got %0h expected 0", imem_req_addr); end
        n_tests++;
        if (if_valid !== 1'b0 || if_ir !== 32'd0 || if_npc !== 32'd0) begin
            n_fail++; $display("FAIL reset_if: got v=%0b ir=%0h npc=%0h expected 0/0/0", if_valid, if_ir, if_npc);
        end
        n_tests++;
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    endtask

    task automatic test_stream();
        step();
        lat = 1;
        if_ready = 1'b1;
        clear_logs();
        first_valid_cyc = -1;
        arm_lat = 1'b1;
        rst_n = 1'b1;
        repeat (14) step();
        n_tests++;
        if (req_log.size() < 8 || got_npc.size() < 8) begin
            n_fail++; $display("FAIL stream_count: got req=%0d pop=%0d expected >=8 each", req_log.size(), got_npc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (req_log[i] !== i) begin n_fail++; $display("FAIL stream_addr[%0d]: got %0h expected %0h", i, req_log[i], i); end
                n_tests++;
                if (got_npc[i] !== 32'(i + 1) || got_ir[i] !== mem_word(32'(i))) begin
                    n_fail++; $display("FAIL stream_word[%0d]: got ir=%0h npc=%0h expected ir=%0h npc=%0h",
                                       i, got_ir[i], got_npc[i], mem_word(32'(i)), i + 1);
                end
            end
            n_tests++;
            if (first_valid_cyc - req_cyc[0] !== 2 - BYP) begin
                n_fail++; $display("FAIL stream_latency: got %0d expected %0d", first_valid_cyc - req_cyc[0], 2 - BYP);
            end
        end
    endtask

    task automatic test_backpressure();
        if_ready = 1'b0;
        repeat (10) step();
        @(negedge clk1);
        n_tests++;
        if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected 4", occupancy); end
        n_tests++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %0b expected 0", imem_req_valid); end
        step();
        if_ready = 1'b1;
        repeat (12) step();
        n_tests++;
        if (got_npc.size() < 20) begin
            n_fail++; $display("FAIL bp_count: got %0d pops expected >=20", got_npc.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                n_tests++;
                if (got_npc[i] !== 32'(i + 1) || got_ir[i] !== mem_word(32'(i))) begin
                    n_fail++; $display("FAIL bp_word[%0d]: got ir=%0h npc=%0h expected ir=%0h npc=%0h",
                                       i, got_ir[i], got_npc[i], mem_word(32'(i)), i + 1);
                end
            end
        end
    endtask

    task automatic test_redirect_drain();
        int j;
        lat = 3;
        if_ready = 1'b1;
        do_reset();
        step();
        step();
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        @(negedge clk1);
        n_tests++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rd_req_valid: got %0b expected 0", imem_req_valid); end
        step();
        halt = 1'b0;
        redirect_valid = 1'b0;
        first_valid_cyc = -1;
        arm_lat = 1'b1;
        @(negedge clk1);
        n_tests++;
        if (if_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL rd_flush: got v=%0b occ=%0d expected 0/0", if_valid, occupancy);
        end
        repeat (25) step();
        n_tests++;
        if (req_log.size() < 3 || got_npc.size() < 4) begin
            n_fail++; $display("FAIL rd_count: got req=%0d pop=%0d expected >=3/>=4", req_log.size(), got_npc.size());
        end else begin
            n_tests++;
            if (req_log[0] !== 0 || req_log[1] !== 1 || req_log[2] !== 32'h20) begin
                n_fail++; $display("FAIL rd_addrs: got %0h %0h %0h expected 0 1 20", req_log[0], req_log[1], req_log[2]);
            end
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (got_npc[i] !== 32'h21 + 32'(i) || got_ir[i] !== mem_word(32'h20 + 32'(i))) begin
                    n_fail++; $display("FAIL rd_word[%0d]: got ir=%0h npc=%0h expected ir=%0h npc=%0h",
                                       i, got_ir[i], got_npc[i], mem_word(32'h20 + 32'(i)), 32'h21 + 32'(i));
                end
            end
            j = 2;
            n_tests++;
            if (first_valid_cyc - req_cyc[j] !== 4 - BYP) begin
                n_fail++; $display("FAIL rd_latency: got %0d expected %0d", first_valid_cyc - req_cyc[j], 4 - BYP);
            end
        end
    endtask

    task automatic test_redirect_pop();
        lat = 1;
        if_ready = 1'b1;
        do_reset();
        repeat (6) step();
        got_ir.delete();
        got_npc.delete();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        @(negedge clk1);
        n_tests++;
        if (if_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL rp_flush: got v=%0b occ=%0d expected 0/0", if_valid, occupancy);
        end
        repeat (10) step();
        n_tests++;
        if (got_npc.size() < 2) begin
            n_fail++; $display("FAIL rp_count: got %0d pops expected >=2", got_npc.size());
        end else begin
            n_tests++;
            if (got_npc[0] !== 32'h101 || got_ir[0] !== mem_word(32'h100)) begin
                n_fail++; $display("FAIL rp_first: got ir=%0h npc=%0h expected ir=%0h npc=101", got_ir[0], got_npc[0], mem_word(32'h100));
            end
            n_tests++;
            if (got_npc[1] !== 32'h102) begin n_fail++; $display("FAIL rp_second: got npc=%0h expected 102", got_npc[1]); end
        end
    endtask

    task automatic test_halt();
        lat = 2;
        if_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 20 && imem_req_addr !== 10'd5; i++) step();
        n_tests++;
        if (imem_req_addr !== 10'd5) begin n_fail++; $display("FAIL halt_reach: got addr %0h expected 5", imem_req_addr); end
        halt = 1'b1;
        repeat (10) step();
        @(negedge clk1);
        n_tests++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_req_valid: got %0b expected 0", imem_req_valid); end
        n_tests++;
        if (req_log.size() !== 5) begin n_fail++; $display("FAIL halt_reqs: got %0d expected 5", req_log.size()); end
        n_tests++;
        if (got_npc.size() !== 5) begin
            n_fail++; $display("FAIL halt_pops: got %0d expected 5", got_npc.size());
        end else begin
            n_tests++;
            if (got_npc[4] !== 32'd5 || got_ir[4] !== mem_word(32'd4)) begin
                n_fail++; $display("FAIL halt_last: got ir=%0h npc=%0h expected ir=%0h npc=5", got_ir[4], got_npc[4], mem_word(32'd4));
            end
        end
        step();
        halt = 1'b0;
        repeat (6) step();
        n_tests++;
        if (req_log.size() < 6 || got_npc.size() < 6) begin
            n_fail++; $display("FAIL resume_count: got req=%0d pop=%0d expected >=6", req_log.size(), got_npc.size());
        end else begin
            n_tests++;
            if (req_log[5] !== 5) begin n_fail++; $display("FAIL resume_addr: got %0h expected 5", req_log[5]); end
            n_tests++;
            if (got_npc[5] !== 32'd6 || got_ir[5] !== mem_word(32'd5)) begin
                n_fail++; $display("FAIL resume_word: got ir=%0h npc=%0h expected ir=%0h npc=6", got_ir[5], got_npc[5], mem_word(32'd5));
            end
        end
    endtask

    task automatic test_async_reset();
        lat = 1;
        if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20 && occupancy !== 3'd3; i++) step();
        n_tests++;
        if (occupancy !== 3'd3) begin n_fail++; $display("FAIL ar_reach: got occ=%0d expected 3", occupancy); end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (if_valid !== 1'b0 || occupancy !== 3'd0 || imem_req_valid !== 1'b0 || if_ir !== 32'd0 || if_npc !== 32'd0) begin
            n_fail++; $display("FAIL ar_outputs: got v=%0b occ=%0d req=%0b ir=%0h npc=%0h expected all 0",
                               if_valid, occupancy, imem_req_valid, if_ir, if_npc);
        end
        n_tests++;
        if (imem_req_addr !== 10'd0) begin n_fail++; $display("FAIL ar_addr: got %0h expected 0", imem_req_addr); end
        step();
        step();
        clear_logs();
        if_ready = 1'b1;
        rst_n = 1'b1;
        repeat (8) step();
        n_tests++;
        if (req_log.size() < 1 || got_npc.size() < 1) begin
            n_fail++; $display("FAIL ar_count: got req=%0d pop=%0d expected >=1", req_log.size(), got_npc.size());
        end else begin
            n_tests++;
            if (req_log[0] !== 0) begin n_fail++; $display("FAIL ar_restart_addr: got %0h expected 0", req_log[0]); end
            n_tests++;
            if (got_npc[0] !== 32'd1 || got_ir[0] !== mem_word(32'd0)) begin
                n_fail++; $display("FAIL ar_restart_word: got ir=%0h npc=%0h expected ir=%0h npc=1", got_ir[0], got_npc[0], mem_word(32'd0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_pop();
        test_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
